// File: rtl/pc_unit_if.sv
// pc_unit_if -- decoder <-> program counter bus.
//   master (decoder side): drives PCSEL, JT, LIT, STALL, IRQ_IN; receives PC, PC_INC, IRQ
//   slave  (pc_unit side): the mirror image
interface pc_unit_if;
  logic [2:0]  PCSEL;   // next-PC select
  logic [31:0] JT;      // jump target (Ra read data)
  logic [15:0] LIT;     // signed word offset
  logic        STALL;   // hold PC / pending state
  logic        IRQ_IN;  // external interrupt pulse
  logic [31:0] PC;      // current instruction address
  logic [31:0] PC_INC;  // PC + 4, link value
  logic        IRQ;     // interrupt request to decoder

  modport master (output PCSEL, JT, LIT, STALL, IRQ_IN,
                  input  PC, PC_INC, IRQ);
  modport slave  (input  PCSEL, JT, LIT, STALL, IRQ_IN,
                  output PC, PC_INC, IRQ);
endinterface

// File: rtl/pc_unit.sv
// pc_unit -- program counter with supervisor bit and interrupt latch.
//   CLK    : clock, rising edge
//   RESET  : async active-high reset (PC=0x80000000, nothing pending)
//   bus    : pc_unit_if.slave (PCSEL/JT/LIT/STALL/IRQ_IN in, PC/PC_INC/IRQ out)
// Optional build macro PC_SUPERVISOR_EN:
//   - a jump may clear but never set PC[31]
//   - IRQ is masked while PC[31] (supervisor) is set; the request stays pending
module pc_unit (
  input  logic     CLK,
  input  logic     RESET,
  pc_unit_if.slave bus
);
  localparam logic [2:0] SEL_INC = 3'd0;
  localparam logic [2:0] SEL_BR  = 3'd1;
  localparam logic [2:0] SEL_JMP = 3'd2;
  localparam logic [2:0] SEL_IRQ = 3'd4;

  // Word addresses (PC >> 2); PC[1:0] is hard-wired to zero.
  localparam logic [29:0] VEC_RESET = 30'h2000_0000;  // 0x80000000
  localparam logic [29:0] VEC_ILLOP = 30'h2000_0001;  // 0x80000004
  localparam logic [29:0] VEC_IRQ   = 30'h2000_0002;  // 0x80000008

  logic [29:0] pc_q;
  logic        pend_q;
  logic [29:0] inc_w, br_w, jmp_w, nxt_w;
  logic [28:0] lit_w;
  logic        jmp_sup;
  logic        take_irq;
  logic        unused_jt_lo;

  // Bit 29 of the word address is the supervisor bit; arithmetic wraps
  // in the low 29 bits only so it is never disturbed.
  assign inc_w = {pc_q[29], pc_q[28:0] + 29'd1};
  assign lit_w = {{13{bus.LIT[15]}}, bus.LIT};
  assign br_w  = {pc_q[29], inc_w[28:0] + lit_w};

`ifdef PC_SUPERVISOR_EN
  assign jmp_sup = pc_q[29] & bus.JT[31];
`else
  assign jmp_sup = bus.JT[31];
`endif
  assign jmp_w        = {jmp_sup, bus.JT[30:2]};
  assign unused_jt_lo = ^bus.JT[1:0];

  always_comb begin
    nxt_w = VEC_ILLOP;  // illop and the undefined encodings 5..7
    case (bus.PCSEL)
      SEL_INC: nxt_w = inc_w;
      SEL_BR:  nxt_w = br_w;
      SEL_JMP: nxt_w = jmp_w;
      SEL_IRQ: nxt_w = VEC_IRQ;
      default: nxt_w = VEC_ILLOP;
    endcase
  end

  assign take_irq = (bus.PCSEL == SEL_IRQ) && !bus.STALL;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pc_q   <= VEC_RESET;
      pend_q <= 1'b0;
    end else begin
      if (!bus.STALL) pc_q <= nxt_w;
      // A new request arriving in the taking cycle wins over the clear,
      // so it is serviced by a second interrupt.
      pend_q <= bus.IRQ_IN | (pend_q & ~take_irq);
    end
  end

  assign bus.PC     = {pc_q, 2'b00};
  assign bus.PC_INC = {inc_w, 2'b00};
`ifdef PC_SUPERVISOR_EN
  assign bus.IRQ = pend_q & ~pc_q[29];
`else
  assign bus.IRQ = pend_q;
`endif
endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;
  logic CLK = 1'b0;
  logic RESET;
  int   n_chk = 0;
  int   n_err = 0;

  logic [31:0] m_pc;
  logic        m_pend;

  pc_unit_if bus ();
  pc_unit dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_inc(input logic [31:0] pc);
    return (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  function automatic logic [31:0] m_next(input logic [31:0] pc, input logic [2:0] sel,
                                         input logic [31:0] jt, input logic [15:0] lit);
    int off;
    logic sup;
    off = int'($signed(lit)) * 4;
`ifdef PC_SUPERVISOR_EN
    sup = pc[31] & jt[31];
`else
    sup = jt[31];
`endif
    case (sel)
      3'd0: return m_inc(pc);
      3'd1: return (pc & 32'h8000_0000) | ((m_inc(pc) + off) & 32'h7FFF_FFFF);
      3'd2: return (jt & 32'h7FFF_FFFC) | (sup ? 32'h8000_0000 : 32'h0);
      3'd4: return 32'h8000_0008;
      default: return 32'h8000_0004;
    endcase
  endfunction

  function automatic logic m_irq();
`ifdef PC_SUPERVISOR_EN
    return m_pend & ~m_pc[31];
`else
    return m_pend;
`endif
  endfunction

  // Called just after a falling edge: drive inputs, check combinational
  // outputs, clock once, advance the model, check registered state.
  task automatic cyc(input logic [2:0] sel, input logic [31:0] jt, input logic [15:0] lit,
                     input logic stall, input logic irq_in);
    bus.PCSEL = sel; bus.JT = jt; bus.LIT = lit; bus.STALL = stall; bus.IRQ_IN = irq_in;
    #1;
    chk("pc_inc", bus.PC_INC, m_inc(m_pc));
    @(posedge CLK);
    m_pend = irq_in | (m_pend & !(sel == 3'd4 && !stall));
    if (!stall) m_pc = m_next(m_pc, sel, jt, lit);
    @(negedge CLK);
    bus.IRQ_IN = 1'b0;
    chk("pc", bus.PC, m_pc);
    chk("irq", {31'b0, bus.IRQ}, {31'b0, m_irq()});
  endtask

  task automatic jmp(input logic [31:0] a);
    cyc(3'd2, a, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    RESET = 1'b1;
    bus.PCSEL = 3'd0; bus.JT = '0; bus.LIT = '0; bus.STALL = 1'b0; bus.IRQ_IN = 1'b1;
    m_pc = 32'h8000_0000; m_pend = 1'b0;
    repeat (2) @(negedge CLK);
    // IRQ_IN held high through reset must be ignored
    bus.IRQ_IN = 1'b0;
    chk("rst_pc", bus.PC, 32'h8000_0000);
    chk("rst_inc", bus.PC_INC, 32'h8000_0004);
    chk("rst_irq", {31'b0, bus.IRQ}, 32'h0);
    RESET = 1'b0;

    // straight-line increment out of reset
    cyc(3'd0, 0, 0, 0, 0); chk("seq1", bus.PC, 32'h8000_0004);
    cyc(3'd0, 0, 0, 0, 0); chk("seq2", bus.PC, 32'h8000_0008);
    cyc(3'd0, 0, 0, 0, 0); chk("seq3", bus.PC, 32'h8000_000C);

    // branches, negative and positive offsets
    jmp(32'h0000_0100); chk("j100", bus.PC, 32'h0000_0100);
    cyc(3'd1, 0, 16'hFFFE, 0, 0); chk("br_neg", bus.PC, 32'h0000_00FC);
    jmp(32'h0000_0100);
    cyc(3'd1, 0, 16'h0003, 0, 0); chk("br_pos", bus.PC, 32'h0000_0110);

    // increment wraps within the low 31 bits
    jmp(32'h7FFF_FFFC);
    cyc(3'd0, 0, 0, 0, 0); chk("wrap_u", bus.PC, 32'h0000_0000);
    cyc(3'd3, 0, 0, 0, 0); chk("illop", bus.PC, 32'h8000_0004);
    jmp(32'hFFFF_FFFC);
    cyc(3'd0, 0, 0, 0, 0); chk("wrap_s", bus.PC, 32'h8000_0000);

    // jump supervisor-bit handling
    jmp(32'h0000_0040);
    jmp(32'h8000_0123);
`ifdef PC_SUPERVISOR_EN
    chk("jmp_u", bus.PC, 32'h0000_0120);
`else
    chk("jmp_u", bus.PC, 32'h8000_0120);
`endif
    cyc(3'd6, 0, 0, 0, 0); chk("sel6", bus.PC, 32'h8000_0004);
    jmp(32'h8000_0040);
    jmp(32'h8000_0123); chk("jmp_s", bus.PC, 32'h8000_0120);

    // interrupt flow
    jmp(32'h8000_0010);
    cyc(3'd0, 0, 0, 0, 1);
`ifdef PC_SUPERVISOR_EN
    chk("irq_mask", {31'b0, bus.IRQ}, 32'h0);
`else
    chk("irq_mask", {31'b0, bus.IRQ}, 32'h1);
`endif
    jmp(32'h0000_0200); chk("irq_user", {31'b0, bus.IRQ}, 32'h1);
    cyc(3'd4, 0, 0, 0, 0); chk("irq_vec", bus.PC, 32'h8000_0008);
    chk("irq_clr", {31'b0, bus.IRQ}, 32'h0);
    jmp(32'h0000_0200);
    cyc(3'd0, 0, 0, 0, 1); chk("irq_again", {31'b0, bus.IRQ}, 32'h1);
    cyc(3'd4, 0, 0, 0, 1);   // new request in the taking cycle
    jmp(32'h0000_0300); chk("irq_keep", {31'b0, bus.IRQ}, 32'h1);
    cyc(3'd4, 0, 0, 0, 0);
    jmp(32'h0000_0300);

    // stall holds PC but still latches the interrupt
    cyc(3'd1, 0, 16'h0005, 1, 1);
    cyc(3'd1, 0, 16'h0005, 1, 0);
    chk("stall_pc", bus.PC, 32'h0000_0300);
    chk("stall_irq", {31'b0, bus.IRQ}, 32'h1);

    // async reset between edges
    #2 RESET = 1'b1;
    #1;
    chk("arst_pc", bus.PC, 32'h8000_0000);
    chk("arst_irq", {31'b0, bus.IRQ}, 32'h0);
    RESET = 1'b0;
    m_pc = 32'h8000_0000; m_pend = 1'b0;
    @(negedge CLK);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cyc(3'($urandom_range(0, 7)), $urandom, 16'($urandom),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
